dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data_memory between the CPU load/store stage (port 0) and the debug/program loader (port 1).
- Performs at most one memory access per cycle. Drives the memory address, write_data and write_enable. Returns read data to the winning port one cycle later.
- Uses round-robin fairness, plus a lock for atomic read-modify-write sequences.
- Sits between the pipeline MEM stage / loader and data_memory.

Parameters:
- ADDR_W, 32, address width passed through to data_memory
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  port 0 access request; held with its fields stable until m0_gnt
- m0_we  in  1  port 0 write (1) / read (0)
- m0_lock  in  1  port 0 keeps ownership after this access
- m0_addr  in  ADDR_W  port 0 address
- m0_wdata  in  DATA_W  port 0 write data
- m0_gnt  out  1  port 0 access performed this cycle
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  DATA_W  port 0 read data
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- mem_address  out  ADDR_W  to data_memory address
- mem_write_data  out  DATA_W  to data_memory write_data
- mem_write_enable  out  1  to data_memory write_enable
- mem_read_data  in  DATA_W  from data_memory read_data (combinational read)

Behaviour:
- FSM states: IDLE (no owner), OWN0, OWN1 (locked owner). A last_winner register tracks the last granted port.
- Reset values, all outputs and state:
  - state=IDLE, last_winner=1, so port 0 wins the first tie.
  - m*_rvalid=0, m*_rdata=0.
  - gnt outputs, mem_write_enable, mem_address and mem_write_data forced to 0 while rst_n=0.
- Grant is combinational from req, state and last_winner:
  - IDLE, single requester: that port wins.
  - IDLE, both requesting: the port != last_winner wins.
  - OWN0: only port 0 may be granted; m1_gnt=0 even if m1_req=1. OWN1 mirrors this.
- At most one gnt is high per cycle. No grant is issued when no request is present.
- Memory drive from the winner:
  - mem_address=winner addr, mem_write_data=winner wdata, mem_write_enable=winner we & gnt.
  - With no winner: mem_write_enable=0 and address/data=0.
- Read latency 1 cycle: for a granted read in cycle N, cycle N+1 has that port's rvalid=1 and rdata=mem_read_data sampled at the end of cycle N.
  - rvalid is a one-cycle pulse.
  - rdata holds its value until the next read on that port.
  - A write gives no rvalid.
- State update on each grant:
  - last_winner <= winner.
  - If winner lock=1, state <= OWN<winner>; else state <= IDLE.
- Releasing a lock:
  - The locked owner releases by issuing a granted access with lock=0.
  - Dropping req while locked also releases: in OWNx with mx_req=0, state returns to IDLE at the next edge and no grant is given that cycle.
- Back-to-back: a port holding req continuously is granted every cycle when alone, and every other cycle when contending without lock.
- Asynchronous reset mid-operation:
  - Aborts any lock and clears pending rvalid, with no spurious rvalid after release.
  - A write in the reset cycle is suppressed because mem_write_enable is forced 0.
- Requesters must not change addr/we/wdata/lock while req=1 and gnt=0. The arbiter does not check this.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and port index constants. ADDR_W/DATA_W defaults also belong there, alongside data_memory's.
- One natural sub-module: rr_pick2, the combinational two-way round-robin picker (req0, req1, last_winner -> gnt0, gnt1).
- FSM, read-return registers and memory mux stay in dmem_arbiter.

Test Plan:
- Reset then single write:
  - Stimulus: rst_n low 2 cycles, release; m0 write addr 0x10 data 0xDEADBEEF.
  - Required: m0_gnt=1 that cycle, mem_write_enable=1, mem_address=0x10.
  - Then m0 read 0x10 -> m0_rvalid=1 next cycle with m0_rdata=0xDEADBEEF.
- Contention tie:
  - Stimulus: both request reads from cycle 0 after reset, m0 addr 0x4, m1 addr 0x8, both held.
  - Required: grants alternate m0, m1, m0, m1. Each rvalid appears on the correct port one cycle after its gnt, with the respective data.
- Lock:
  - Stimulus: m1 read 0x20 with lock=1, then write 0x20 with lock=0, while m0_req is held high.
  - Required: m0_gnt=0 for both m1 cycles; m0 is granted in the cycle after the unlocking write.
- Lock abandon:
  - Stimulus: m0 locked read, then m0_req=0 for 1 cycle while m1_req=1.
  - Required: no grant that cycle, state returns to IDLE, m1 is granted the following cycle.
- Reset mid-lock:
  - Stimulus: assert rst_n=0 asynchronously during OWN0 with a write pending.
  - Required: mem_write_enable drops immediately, no rvalid occurs, and after release port 0 wins a tie.
- No request:
  - Stimulus: 10 idle cycles.
  - Required: mem_write_enable=0, both gnt=0, both rvalid=0 throughout.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Brief    : Shared types and constants for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;

    localparam logic c_PORT0 = 1'b0;
    localparam logic c_PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Brief    : Combinational two-way round-robin picker; a tie goes to the port
//            that did not win last.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_winner,
    output logic o_gnt0,
    output logic o_gnt1
);

    assign o_gnt0 = i_req0 & (~i_req1 |  i_last_winner);
    assign o_gnt1 = i_req1 & (~i_req0 | ~i_last_winner);

endmodule : rr_pick2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares single-port data memory between the MEM stage (port 0)
//            and the debug loader (port 1) with round-robin plus locking.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

    arb_state_t        r_state;
    logic              r_last_winner;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_pick0;
    logic              w_pick1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_win_lock;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    rr_pick2 u_pick (
        .i_req0        (m0_req),
        .i_req1        (m1_req),
        .i_last_winner (r_last_winner),
        .o_gnt0        (w_pick0),
        .o_gnt1        (w_pick1)
    );

    // A locked owner excludes the other port; grants are killed during reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt0 = w_pick0;
                w_gnt1 = w_pick1;
            end
            ST_OWN0: w_gnt0 = m0_req;
            ST_OWN1: w_gnt1 = m1_req;
            default: ;
        endcase
        if (!rst_n) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    always_comb begin
        w_addr     = '0;
        w_wdata    = '0;
        w_win_we   = 1'b0;
        w_win_lock = 1'b0;
        if (w_gnt0) begin
            w_addr     = m0_addr;
            w_wdata    = m0_wdata;
            w_win_we   = m0_we;
            w_win_lock = m0_lock;
        end else if (w_gnt1) begin
            w_addr     = m1_addr;
            w_wdata    = m1_wdata;
            w_win_we   = m1_we;
            w_win_lock = m1_lock;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_last_winner <= c_PORT1;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            // No grant means either idle or the owner dropped req: both release.
            if (w_gnt0 || w_gnt1) begin
                r_last_winner <= w_gnt1 ? c_PORT1 : c_PORT0;
                if (w_win_lock) begin
                    r_state <= w_gnt1 ? ST_OWN1 : ST_OWN0;
                end else begin
                    r_state <= ST_IDLE;
                end
            end else begin
                r_state <= ST_IDLE;
            end

            r_rvalid0 <= w_gnt0 & ~m0_we;
            r_rvalid1 <= w_gnt1 & ~m1_we;
            if (w_gnt0 && !m0_we) begin
                r_rdata0 <= mem_read_data;
            end
            if (w_gnt1 && !m1_we) begin
                r_rdata1 <= mem_read_data;
            end
        end
    end

    assign m0_gnt           = w_gnt0;
    assign m1_gnt           = w_gnt1;
    assign m0_rvalid        = r_rvalid0;
    assign m1_rvalid        = r_rvalid1;
    assign m0_rdata         = r_rdata0;
    assign m1_rdata         = r_rdata1;
    assign mem_address      = w_addr;
    assign mem_write_data   = w_wdata;
    assign mem_write_enable = w_win_we & (w_gnt0 | w_gnt1);

endmodule : dmem_arbiter
`default_nettype wire
